dct_zigzag_reorder: RTL
=======================

DCT_ZIGZAG_REORDER -- requirements
Module: dct_zigzag_reorder

Interface
REQ-001 SHALL have parameter WIDTH, default 12: signed coefficient width, legal range 8..32.
REQ-002 SHALL have parameter NUM_BANKS, default 2: number of 64-entry block banks, legal range 1..4.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-005 SHALL have port s_valid, input, 1 bit: column vector valid.
REQ-006 SHALL have port s_ready, output, 1 bit: column vector accepted when s_valid && s_ready.
REQ-007 SHALL have port s_col, input, 3 bits: producer's column index; used only by the checker in REQ-028.
REQ-008 SHALL have port s_vec, input, [0:7] x WIDTH signed: s_vec[k] is the coefficient at row v=k of the current column.
REQ-009 SHALL have port zz_mode, input, 1 bit: 1 = zigzag scan order, 0 = raster order.
REQ-010 SHALL have port m_valid, m_ready, m_data (WIDTH, signed), m_last, m_u (3 bits), m_v (3 bits): output coefficient stream plus its (u,v) position.
REQ-011 SHALL have port col_err, output, 1 bit: sticky column-order error flag.

Function
REQ-012 SHALL keep an internal column counter c (0..7); each accepted beat writes s_vec[k] to entry (u=c, v=k) of bank wr_bank, so raster index = v*8+u.
REQ-013 SHALL treat the 8th accepted beat (c=7) as block complete: mark wr_bank full, reset c to 0 and advance wr_bank modulo NUM_BANKS.
REQ-014 SHALL drive s_ready = !full[wr_bank]; s_ready SHALL be 0 while rst_n is low.
REQ-015 SHALL, when rd_bank is full, emit 64 beats from it, one per m_valid && m_ready handshake.
REQ-016 SHALL sample zz_mode once, on the first output beat of each block, and hold that mode for all 64 beats of the block.
REQ-017 SHALL use raster order when the mode is 0: beat n gives v=n>>3 and u=n&7.
REQ-018 SHALL use the standard JPEG 8x8 zigzag order when the mode is 1: (u,v) = (0,0),(1,0),(0,1),(0,2),(1,1),(2,0),(3,0),(2,1),... ending at (7,7).
REQ-019 SHALL drive m_u and m_v with the position of the current m_data.
REQ-020 SHALL assert m_last on beat 63 only.
REQ-021 SHALL register its outputs: m_valid first rises one cycle after the 8th-column handshake, when that bank is rd_bank.
REQ-022 SHALL hold m_data, m_u, m_v and m_last stable while m_valid=1 and m_ready=0.
REQ-023 SHALL sustain one beat per cycle when m_ready=1, with no bubble between consecutive blocks if the next bank is already full.
REQ-024 SHALL, on the m_last handshake, clear full[rd_bank] and advance rd_bank modulo NUM_BANKS.
REQ-025 SHALL, when a bank is freed in the same cycle a writer stalls on it, assert s_ready for that bank from the next cycle.
REQ-026 SHALL, with NUM_BANKS=1, alternate strictly between fill and drain, keeping s_ready=0 during drain.

Reset
REQ-027 SHALL, on rst_n low: clear all full flags, c, wr_bank, rd_bank, beat counter and col_err; drive m_valid, m_last, m_data, m_u and m_v to 0; discard any partial block without emitting m_last.

Configuration
REQ-028 SHALL, with macro DCT_ZZ_COLCHK_EN defined: on each accepted beat where s_col != c, set col_err=1 until reset, while still writing data at column c.
REQ-029 SHALL, without DCT_ZZ_COLCHK_EN: tie col_err to 0, ignore s_col, and synthesise no checker logic.

Verification
REQ-030 Raster: one block with s_vec[k]=k*8+c, zz_mode=0, m_ready=1 -> m_data 0,1,...,63, m_last only on value 63, m_valid the cycle after the 8th column.
REQ-031 Zigzag: same block, zz_mode=1 -> m_data 0,1,8,16,9,2,3,10,...,63, (m_u,m_v) of last beat = (7,7).
REQ-032 Backpressure and mode change: m_ready=0 for 5 cycles at beat 10, zz_mode toggled mid-block -> outputs held constant, order unchanged, no beat lost or duplicated.
REQ-033 Bank full: NUM_BANKS=2, m_ready=0, 3 blocks offered -> s_ready=0 after 16 beats; release m_ready -> 192 beats in order, exactly 3 m_last.
REQ-034 Reset mid-block: rst_n low after column 4 of block 1 -> all outputs 0, next full block emitted intact.
REQ-035 Checker (macro defined): s_col=3 when c=2 -> col_err=1 and held; macro undefined -> col_err stays 0.

Source files
------------

// File: rtl/dct_zigzag_reorder_if.sv
// Stream bundle for dct_zigzag_reorder: column-vector input stream and
// coefficient output stream with its (u,v) position.
interface dct_zigzag_reorder_if #(
    parameter int WIDTH = 12
);
    logic                    s_valid;
    logic                    s_ready;
    logic [2:0]              s_col;
    logic signed [WIDTH-1:0] s_vec [0:7];
    logic                    zz_mode;

    logic                    m_valid;
    logic                    m_ready;
    logic signed [WIDTH-1:0] m_data;
    logic                    m_last;
    logic [2:0]              m_u;
    logic [2:0]              m_v;

    modport slave (
        input  s_valid, s_col, s_vec, zz_mode, m_ready,
        output s_ready, m_valid, m_data, m_last, m_u, m_v
    );

    modport master (
        output s_valid, s_col, s_vec, zz_mode, m_ready,
        input  s_ready, m_valid, m_data, m_last, m_u, m_v
    );
endinterface

// File: rtl/dct_zigzag_reorder.sv
// Banked 8x8 block buffer: writes one column per beat, reads 64 coefficients
// in raster or JPEG zigzag order. Optional column-order checker: DCT_ZZ_COLCHK_EN.
module dct_zigzag_reorder #(
    parameter int WIDTH     = 12,
    parameter int NUM_BANKS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dct_zigzag_reorder_if.slave   bus,
    output logic                  col_err
);
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int AW = BW + 6;
    localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);

    // Raster index (v*8+u) for each zigzag beat
    localparam logic [5:0] ZZ_IDX [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic signed [WIDTH-1:0] mem [2**AW];
    logic [NUM_BANKS-1:0]    full;
    logic [2:0]              col;
    logic [BW-1:0]           wr_bank;
    logic [BW-1:0]           rd_bank;
    logic [BW-1:0]           fetch_bank;
    logic [5:0]              fetch_beat;
    logic                    mode_q;
    logic                    wr_fire;
    logic                    out_fire;
    logic                    last_fire;
    logic                    rd_fire;
    logic                    fetch_mode;
    logic [5:0]              fetch_idx;

    function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
        return (b == LAST_BANK) ? '0 : b + 1'b1;
    endfunction

    assign bus.s_ready = rst_n & ~full[wr_bank];

    // The output register always holds a beat of rd_bank; the fetch pointer runs
    // one beat ahead so blocks chain without a bubble. Fetching is blocked while
    // the final beat of the same bank is still pending (single-bank wrap).
    always_comb begin
        wr_fire    = bus.s_valid & bus.s_ready;
        out_fire   = bus.m_valid & bus.m_ready;
        last_fire  = out_fire & bus.m_last;
        rd_fire    = (~bus.m_valid | bus.m_ready) & full[fetch_bank]
                   & ~(bus.m_valid & bus.m_last & (fetch_bank == rd_bank));
        fetch_mode = (fetch_beat == 6'd0) ? bus.zz_mode : mode_q;
        fetch_idx  = fetch_mode ? ZZ_IDX[fetch_beat] : fetch_beat;
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int unsigned k = 0; k < 8; k++) begin
                mem[{wr_bank, 3'(k), col}] <= bus.s_vec[3'(k)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full       <= '0;
            col        <= '0;
            wr_bank    <= '0;
            rd_bank    <= '0;
            fetch_bank <= '0;
            fetch_beat <= '0;
            mode_q     <= 1'b0;
        end else begin
            if (wr_fire) begin
                col <= col + 3'd1;
                if (col == 3'd7) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= next_bank(wr_bank);
                end
            end
            if (last_fire) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= next_bank(rd_bank);
            end
            if (rd_fire) begin
                fetch_beat <= fetch_beat + 6'd1;
                mode_q     <= fetch_mode;
                if (fetch_beat == 6'd63) begin
                    fetch_bank <= next_bank(fetch_bank);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_last  <= 1'b0;
            bus.m_u     <= '0;
            bus.m_v     <= '0;
        end else if (rd_fire) begin
            bus.m_valid <= 1'b1;
            bus.m_data  <= mem[{fetch_bank, fetch_idx}];
            bus.m_last  <= (fetch_beat == 6'd63);
            bus.m_u     <= fetch_idx[2:0];
            bus.m_v     <= fetch_idx[5:3];
        end else if (out_fire) begin
            bus.m_valid <= 1'b0;
            bus.m_last  <= 1'b0;
        end
    end

`ifdef DCT_ZZ_COLCHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_err <= 1'b0;
        end else if (wr_fire && (bus.s_col != col)) begin
            col_err <= 1'b1;
        end
    end
`else
    assign col_err = 1'b0;
`endif

endmodule
